// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus carry flop, iterated LSB-first over WIDTH cycles.
// done pulses WIDTH cycles after the accept edge; start is ignored unless idle (no queuing).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_c;
  logic [CW-1:0]    r_cnt;

  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_res_nxt;

  assign w_s = r_a[0] ^ r_b[0] ^ r_c;
  assign w_c = (r_a[0] & r_b[0]) | ((r_a[0] ^ r_b[0]) & r_c);

  // New sum bit enters at the MSB; shift form also covers WIDTH=1.
  assign w_res_nxt = (r_res >> 1) | (WIDTH'(w_s) << (WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_c     <= cin;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= w_c;
          r_res <= w_res_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST_BIT) begin
            sum     <= w_res_nxt;
            cout    <= w_c;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 and WIDTH=1; expected results come from plain integer addition.
module tb_serial_adder;

  typedef struct packed {
    logic [7:0]  s;
    logic        c;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned cyc = 0;

  logic        start8, cin8, busy8, done8, cout8;
  logic [7:0]  a8, b8, sum8;
  logic        start1, cin1, busy1, done1, cout1;
  logic [0:0]  a1, b1, sum1;

  exp_t q8[$];
  exp_t q1[$];
  exp_t m8, m1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] prev8_s;
  logic       prev8_c;
  logic       prev1_s;
  logic       prev1_c;

  serial_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL w8_spurious_done: done=1 at cycle %0d, expected no pulse", cyc);
      end else begin
        m8 = q8.pop_front();
        chk("w8_sum", 32'(sum8), 32'(m8.s));
        chk("w8_cout", 32'(cout8), 32'(m8.c));
        chk("w8_done_cycle", cyc, m8.cyc);
      end
    end
    if (done1 === 1'b1) begin
      if (q1.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL w1_spurious_done: done=1 at cycle %0d, expected no pulse", cyc);
      end else begin
        m1 = q1.pop_front();
        chk("w1_sum", 32'(sum1), 32'(m1.s[0]));
        chk("w1_cout", 32'(cout1), 32'(m1.c));
        chk("w1_done_cycle", cyc, m1.cyc);
      end
    end
  end

  function automatic exp_t model(input int unsigned av, input int unsigned bv,
                                 input int unsigned cv, input int unsigned width,
                                 input int unsigned done_cyc);
    exp_t e;
    int unsigned total;
    total = av + bv + cv;
    e.s   = 8'(total % (1 << width));
    e.c   = 1'(total >> width);
    e.cyc = done_cyc;
    return e;
  endfunction

  // One 8-bit operation; operands are scrambled during RUN to show they are don't-care.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    exp_t e;
    @(negedge clk);
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
    e = model(av, bv, cv, 8, cyc + 1 + 8);
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("w8_busy_run", 32'(busy8), 32'd1);
      chk("w8_sum_held", 32'(sum8), 32'(prev8_s));
      chk("w8_cout_held", 32'(cout8), 32'(prev8_c));
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      @(negedge clk);
    end
    chk("w8_busy_at_done", 32'(busy8), 32'd0);
    @(negedge clk);
    chk("w8_done_single", 32'(done8), 32'd0);
    prev8_s = e.s;
    prev8_c = e.c;
  endtask

  task automatic op1(input logic av, input logic bv, input logic cv);
    exp_t e;
    @(negedge clk);
    a1 = av; b1 = bv; cin1 = cv; start1 = 1'b1;
    e = model(32'(av), 32'(bv), 32'(cv), 1, cyc + 1 + 1);
    q1.push_back(e);
    @(negedge clk);
    start1 = 1'b0;
    chk("w1_busy_run", 32'(busy1), 32'd1);
    chk("w1_sum_held", 32'(sum1), 32'(prev1_s));
    a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
    @(negedge clk);
    chk("w1_busy_at_done", 32'(busy1), 32'd0);
    @(negedge clk);
    chk("w1_done_single", 32'(done1), 32'd0);
    prev1_s = e.s[0];
    prev1_c = e.c;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    prev8_s = '0; prev8_c = 1'b0; prev1_s = 1'b0; prev1_c = 1'b0;

    @(negedge clk);
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_done8", 32'(done8), 32'd0);
    chk("rst_sum8", 32'(sum8), 32'd0);
    chk("rst_cout8", 32'(cout8), 32'd0);
    chk("rst_sum1", 32'(sum1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    op8(8'h35, 8'h4A, 1'b0);
    op8(8'hFF, 8'h01, 1'b0);
    op8(8'hFF, 8'hFF, 1'b1);

    // A second start during RUN must be dropped entirely.
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(model(32'h10, 32'h20, 0, 8, cyc + 1 + 8));
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'h77; b8 = 8'h99;
    repeat (7) @(negedge clk);
    chk("w8_ignored_start_idle", 32'(busy8), 32'd0);
    prev8_s = 8'h30; prev8_c = 1'b0;

    // Start held high: one operation every WIDTH+2 cycles.
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    for (int k = 0; k < 3; k++)
      q8.push_back(model(1, 1, 0, 8, cyc + 1 + 8 + 10 * k));
    repeat (29) @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    chk("w8_held_start_stopped", 32'(busy8), 32'd0);
    prev8_s = 8'h02; prev8_c = 1'b0;

    for (int i = 0; i < 25; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom));

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    a8 = 8'hC3; b8 = 8'h3C; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    chk("w8_busy_before_abort", 32'(busy8), 32'd1);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy8", 32'(busy8), 32'd0);
    chk("abort_done8", 32'(done8), 32'd0);
    chk("abort_sum8", 32'(sum8), 32'd0);
    chk("abort_cout8", 32'(cout8), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    prev8_s = '0; prev8_c = 1'b0; prev1_s = 1'b0; prev1_c = 1'b0;
    repeat (12) @(negedge clk);
    chk("post_abort_idle", 32'(busy8), 32'd0);
    op8(8'h0F, 8'h01, 1'b0);

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      op1(v[2], v[1], v[0]);
    end
    for (int i = 0; i < 8; i++)
      op1(1'($urandom), 1'($urandom), 1'($urandom));

    repeat (3) @(negedge clk);
    chk("w8_queue_drained", 32'(q8.size()), 32'd0);
    chk("w1_queue_drained", 32'(q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder: the addition counterpart to the full-subtractor datapath.
- One registered full-adder cell with a carry flip-flop, iterated LSB-first over WIDTH clock cycles.
- Start/busy/done handshake with parallel operand load and parallel result.
- Sits beside the subtractor blocks as a compact, area-cheap arithmetic unit for multi-cycle datapaths.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1 to 32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; latched when start is accepted
- b  input  WIDTH  operand B; latched when start is accepted
- cin  input  1  carry-in; latched when start is accepted
- busy  output  1  high while bits are being processed (RUN)
- done  output  1  single-cycle pulse when the result is valid
- sum  output  WIDTH  registered result, (a + b + cin) mod 2^WIDTH
- cout  output  1  registered carry-out of the MSB

Behaviour:
- Reset: rst_n=0 clears everything immediately, without waiting for a clock edge.
  - State goes to IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Operand shift registers, carry flip-flop and bit counter are cleared.
- States:
  - IDLE -> RUN on an edge with start=1.
  - RUN -> DONE after WIDTH bit-steps.
  - DONE -> IDLE unconditionally on the next edge.
- Accept edge (E0, IDLE with start=1):
  - Latch a and b into shift registers.
  - Load carry flip-flop with cin.
  - Set bit counter to 0.
- RUN:
  - Edge Ek (k=1..WIDTH) processes bit i=k-1 using s = a_i ^ b_i ^ c and c' = a_i&b_i | (a_i^b_i)&c.
  - s shifts into the result shift register from the MSB side, so after WIDTH shifts bit 0 is in position 0.
  - Operand registers shift right by 1 and the counter increments.
- Completion edge (E_WIDTH):
  - Full result word is copied to sum, final carry to cout.
  - State goes to DONE and done=1.
- Latency: done is high for exactly one cycle, from E_WIDTH to E_WIDTH+1, where E0 is the accept edge.
- Output timing:
  - busy=1 from E0 to E_WIDTH; busy=0 in IDLE and DONE.
  - sum and cout hold the previous result throughout RUN and DONE until the next completion edge overwrites them. There are no intermediate values on the outputs.
- start handling:
  - Ignored in RUN and DONE; no queuing.
  - A start held high through DONE is accepted at E_WIDTH+1, the first IDLE edge. Back-to-back throughput is one operation per WIDTH+2 cycles.
- Operands:
  - a, b and cin are don't-care except at the accept edge.
  - Changing them mid-RUN must not affect the result.
- Overflow: wrap-around is modulo 2^WIDTH, and cout carries the overflow bit.
- WIDTH=1: the block reduces to a registered full adder.
  - Accept edge, then one RUN edge, then DONE.
  - sum and cout must match the full-adder truth table for all 8 combinations of a, b, cin.
- Reset mid-RUN or in DONE:
  - Operation aborts, all outputs return to their reset values, and no done pulse is issued.
  - First start after rst_n releases behaves normally.
- Clock counter width is clog2(WIDTH+1) bits. No combinational path from inputs to outputs.

Test Plan:
- WIDTH=8, a=0x35, b=0x4A, cin=0, start pulsed 1 cycle -> busy high 8 cycles, done pulse at E8, sum=0x7F, cout=0.
- WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1. Previous sum held during the second RUN.
- WIDTH=1, all 8 (a,b,cin) combinations applied in sequence -> (sum,cout) = 00,10,10,01,10,01,01,11 for inputs 000..111 in a,b,cin order. Each done at E1.
- WIDTH=8: pulse start with a=0x10, b=0x20; at E3 pulse start with a=0xAA, b=0x55 and change a/b -> second start ignored, result sum=0x30, cout=0, exactly one done pulse.
- WIDTH=8: start held high continuously with a=0x01, b=0x01 -> done pulses at E8, E18, E28 (period 10 cycles), sum=0x02 each time.
- WIDTH=8: start an operation, assert rst_n=0 between clock edges at E4 -> busy, done, sum and cout go to 0 immediately. No done pulse afterwards. Release reset, start a=0x0F, b=0x01 -> sum=0x10, cout=0.
